// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - opcode, pcmux and hazard-controller shared types
package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;
endpackage

package pcmux;
    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10
    } pcmux_sel_t;
endpackage

package hazard_types;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } hazard_ctrl_t;

    localparam int HZ_CNT_W = 32;

    localparam hazard_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                          exmem_en: 1'b1, memwb_en: 1'b1, default: 1'b0};

    // A producer only matters if it really writes a non-zero register that ID reads.
    function automatic logic src_match(input logic regwrite, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic use_rs1,
                                       input logic [4:0] rs2, input logic use_rs2);
        return regwrite && (rd != 5'd0) &&
               ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
    endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status in, stall/flush/redirect controls out
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = hazard_types::HZ_CNT_W);
    logic                     imem_read;
    logic                     imem_resp;
    logic                     dmem_read;
    logic                     dmem_write;
    logic                     dmem_resp;
    logic [4:0]               id_rs1;
    logic [4:0]               id_rs2;
    logic                     id_use_rs1;
    logic                     id_use_rs2;
    logic                     ex_valid;
    rv32i_types::rv32i_opcode ex_opcode;
    logic                     ex_br_en;
    logic                     ex_is_load;
    logic [4:0]               ex_rd;
    logic [4:0]               mem_rd;
    logic [4:0]               wb_rd;
    logic                     ex_regwrite;
    logic                     mem_regwrite;
    logic                     wb_regwrite;
    logic                     ex_muldiv;

    logic                     pc_en;
    pcmux::pcmux_sel_t        pcmux_sel;
    logic                     ifid_en;
    logic                     idex_en;
    logic                     exmem_en;
    logic                     memwb_en;
    logic                     ifid_flush;
    logic                     idex_flush;
    logic                     exmem_flush;
    logic                     muldiv_busy;
    logic [CNT_W-1:0]         stall_cycles;
    logic [CNT_W-1:0]         flush_events;

    modport master (
        output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_opcode, ex_br_en, ex_is_load,
               ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite, ex_muldiv,
        input  pc_en, pcmux_sel, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, muldiv_busy, stall_cycles, flush_events
    );

    modport slave (
        input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_opcode, ex_br_en, ex_is_load,
               ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite, ex_muldiv,
        output pc_en, pcmux_sel, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, muldiv_busy, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_muldiv_sequencer.sv
// rtl/pipeline_hazard_ctrl_muldiv_sequencer.sv - multi-cycle mul/div occupancy FSM
module muldiv_sequencer
    import hazard_types::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mem_stall,
    output logic busy,
    output logic hold
);
    localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

    muldiv_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The entry cycle already counts as one execution cycle, hence LAT-1 BUSY cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        hold      = 1'b0;
        unique case (state)
            IDLE: begin
                hold = start;
                if (start && !mem_stall) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(MULDIV_LAT - 1);
                end
            end
            BUSY: begin
                busy    = 1'b1;
                hold    = 1'b1;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                if (!mem_stall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/redirect controller for the 5-stage rv32i pipeline
module pipeline_hazard_ctrl
    import rv32i_types::*;
    import pcmux::*;
    import hazard_types::*;
#(
    parameter bit FWD_EN     = 1'b1,
    parameter bit RF_BYPASS  = 1'b1,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = HZ_CNT_W
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);
    logic         mem_stall;
    logic         taken;
    logic         redirect;
    logic         ex_hit;
    logic         mem_hit;
    logic         wb_hit;
    logic         hazard;
    logic         md_busy;
    logic         md_hold;
    logic         flush_take;
    pcmux_sel_t   redirect_sel;
    pcmux_sel_t   pcmux_next;
    hazard_ctrl_t ctrl;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign mem_stall = (hz.imem_read & ~hz.imem_resp) |
                       ((hz.dmem_read | hz.dmem_write) & ~hz.dmem_resp);

    always_comb begin
        taken        = 1'b0;
        redirect_sel = pc_plus4;
        case (hz.ex_opcode)
            op_br:   begin taken = hz.ex_br_en; redirect_sel = alu_out;  end
            op_jal:  begin taken = 1'b1;        redirect_sel = alu_out;  end
            op_jalr: begin taken = 1'b1;        redirect_sel = alu_mod2; end
            default: ;
        endcase
    end

    assign redirect = hz.ex_valid & taken;

    assign ex_hit  = src_match(hz.ex_regwrite, hz.ex_rd, hz.id_rs1, hz.id_use_rs1,
                               hz.id_rs2, hz.id_use_rs2);
    assign mem_hit = src_match(hz.mem_regwrite, hz.mem_rd, hz.id_rs1, hz.id_use_rs1,
                               hz.id_rs2, hz.id_use_rs2);
    assign wb_hit  = src_match(hz.wb_regwrite, hz.wb_rd, hz.id_rs1, hz.id_use_rs1,
                               hz.id_rs2, hz.id_use_rs2);

    // With forwarding only a load in EX cannot supply its result in time.
    assign hazard = FWD_EN ? (ex_hit & hz.ex_is_load)
                           : (ex_hit | mem_hit | (wb_hit & !RF_BYPASS));

    muldiv_sequencer #(.MULDIV_LAT(MULDIV_LAT)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (hz.ex_valid & hz.ex_muldiv),
        .mem_stall (mem_stall),
        .busy      (md_busy),
        .hold      (md_hold)
    );

    always_comb begin
        ctrl       = '0;
        pcmux_next = pc_plus4;
        flush_take = 1'b0;
        if (rst) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (mem_stall) begin
            ctrl = '0;
        end else if (md_hold) begin
            // EX keeps the mul/div; a bubble drains into MEM behind it.
            ctrl.exmem_en    = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.memwb_en    = 1'b1;
        end else if (redirect) begin
            ctrl            = CTRL_RUN;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            pcmux_next      = redirect_sel;
            flush_take      = 1'b1;
        end else if (hazard) begin
            ctrl            = CTRL_RUN;
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end else begin
            ctrl = CTRL_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctrl.pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flush_take && (flush_q != '1))  flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.pc_en        = ctrl.pc_en;
    assign hz.pcmux_sel    = pcmux_next;
    assign hz.ifid_en      = ctrl.ifid_en;
    assign hz.idex_en      = ctrl.idex_en;
    assign hz.exmem_en     = ctrl.exmem_en;
    assign hz.memwb_en     = ctrl.memwb_en;
    assign hz.ifid_flush   = ctrl.ifid_flush;
    assign hz.idex_flush   = ctrl.idex_flush;
    assign hz.exmem_flush  = ctrl.exmem_flush;
    assign hz.muldiv_busy  = md_busy & ~rst;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    import rv32i_types::*;
    import pcmux::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) ifa ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  ifb ();

    pipeline_hazard_ctrl #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .MULDIV_LAT(LAT), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .hz(ifa)
    );
    pipeline_hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b0), .MULDIV_LAT(LAT), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .hz(ifb)
    );

    assign ifb.imem_read    = ifa.imem_read;
    assign ifb.imem_resp    = ifa.imem_resp;
    assign ifb.dmem_read    = ifa.dmem_read;
    assign ifb.dmem_write   = ifa.dmem_write;
    assign ifb.dmem_resp    = ifa.dmem_resp;
    assign ifb.id_rs1       = ifa.id_rs1;
    assign ifb.id_rs2       = ifa.id_rs2;
    assign ifb.id_use_rs1   = ifa.id_use_rs1;
    assign ifb.id_use_rs2   = ifa.id_use_rs2;
    assign ifb.ex_valid     = ifa.ex_valid;
    assign ifb.ex_opcode    = ifa.ex_opcode;
    assign ifb.ex_br_en     = ifa.ex_br_en;
    assign ifb.ex_is_load   = ifa.ex_is_load;
    assign ifb.ex_rd        = ifa.ex_rd;
    assign ifb.mem_rd       = ifa.mem_rd;
    assign ifb.wb_rd        = ifa.wb_rd;
    assign ifb.ex_regwrite  = ifa.ex_regwrite;
    assign ifb.mem_regwrite = ifa.mem_regwrite;
    assign ifb.wb_regwrite  = ifa.wb_regwrite;
    assign ifb.ex_muldiv    = ifa.ex_muldiv;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // ctrl bit order: pc ifid idex exmem memwb | ifid_fl idex_fl exmem_fl
    typedef struct {
        logic [7:0] ctrl;
        logic [1:0] sel;
        logic       busy;
        logic       stall;
        logic       flush_take;
    } exp_t;

    int     md_left = 0;
    bit     md_done = 1'b0;
    longint stall_m [2];
    longint flush_m [2];
    exp_t   ea, eb;

    function automatic longint cnt_max(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    function automatic longint sat_inc(input longint v, input bit inc, input longint mx);
        return (inc && v < mx) ? v + 1 : v;
    endfunction

    function automatic bit reads_reg(input logic [4:0] r);
        return (r != 5'd0) && ((ifa.id_use_rs1 && ifa.id_rs1 == r) ||
                               (ifa.id_use_rs2 && ifa.id_rs2 == r));
    endfunction

    function automatic exp_t model(input bit fwd, input bit byp);
        exp_t e;
        bit redirect, hazard, ex_dep, hold;
        e.stall = (ifa.imem_read && !ifa.imem_resp) ||
                  ((ifa.dmem_read || ifa.dmem_write) && !ifa.dmem_resp);
        redirect = ifa.ex_valid && ((ifa.ex_opcode == op_br && ifa.ex_br_en) ||
                                    ifa.ex_opcode == op_jal || ifa.ex_opcode == op_jalr);
        ex_dep = ifa.ex_regwrite && reads_reg(ifa.ex_rd);
        hazard = fwd ? (ex_dep && ifa.ex_is_load)
                     : (ex_dep || (ifa.mem_regwrite && reads_reg(ifa.mem_rd)) ||
                        (!byp && ifa.wb_regwrite && reads_reg(ifa.wb_rd)));
        hold = (md_left > 0) || (!md_done && ifa.ex_valid && ifa.ex_muldiv);
        e.sel        = 2'(pc_plus4);
        e.flush_take = 1'b0;
        e.busy       = !rst && ((md_left > 0) || md_done);
        if (rst)            e.ctrl = 8'b00000_111;
        else if (e.stall)   e.ctrl = 8'b00000_000;
        else if (hold)      e.ctrl = 8'b00011_001;
        else if (redirect) begin
            e.ctrl       = 8'b11111_110;
            e.sel        = (ifa.ex_opcode == op_jalr) ? 2'(alu_mod2) : 2'(alu_out);
            e.flush_take = 1'b1;
        end
        else if (hazard)    e.ctrl = 8'b00111_010;
        else                e.ctrl = 8'b11111_000;
        return e;
    endfunction

    always @(negedge clk) begin
        ea = model(1'b1, 1'b1);
        eb = model(1'b0, 1'b0);
        check("a.ctrl", 64'({ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.memwb_en,
                             ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush}), 64'(ea.ctrl));
        check("b.ctrl", 64'({ifb.pc_en, ifb.ifid_en, ifb.idex_en, ifb.exmem_en, ifb.memwb_en,
                             ifb.ifid_flush, ifb.idex_flush, ifb.exmem_flush}), 64'(eb.ctrl));
        check("a.sel",   64'(ifa.pcmux_sel),    64'(ea.sel));
        check("b.sel",   64'(ifb.pcmux_sel),    64'(eb.sel));
        check("a.busy",  64'(ifa.muldiv_busy),  64'(ea.busy));
        check("b.busy",  64'(ifb.muldiv_busy),  64'(eb.busy));
        check("a.stall", 64'(ifa.stall_cycles), 64'(stall_m[0]));
        check("b.stall", 64'(ifb.stall_cycles), 64'(stall_m[1]));
        check("a.flush", 64'(ifa.flush_events), 64'(flush_m[0]));
        check("b.flush", 64'(ifb.flush_events), 64'(flush_m[1]));
    end

    always @(posedge clk) begin
        if (rst) begin
            md_left    <= 0;
            md_done    <= 1'b0;
            stall_m[0] <= 0;
            stall_m[1] <= 0;
            flush_m[0] <= 0;
            flush_m[1] <= 0;
        end else begin
            stall_m[0] <= sat_inc(stall_m[0], !ea.ctrl[7], cnt_max(0));
            stall_m[1] <= sat_inc(stall_m[1], !eb.ctrl[7], cnt_max(1));
            flush_m[0] <= sat_inc(flush_m[0], ea.flush_take, cnt_max(0));
            flush_m[1] <= sat_inc(flush_m[1], eb.flush_take, cnt_max(1));
            if (md_left > 0) begin
                md_left <= md_left - 1;
                if (md_left == 1) md_done <= 1'b1;
            end else if (md_done) begin
                if (!ea.stall) md_done <= 1'b0;
            end else if (ifa.ex_valid && ifa.ex_muldiv && !ea.stall) begin
                md_left <= LAT - 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    rv32i_opcode op_tab [7] = '{op_lui, op_jal, op_jalr, op_br, op_load, op_reg, op_imm};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        ifa.imem_read = 1'b0; ifa.imem_resp = 1'b0;
        ifa.dmem_read = 1'b0; ifa.dmem_write = 1'b0; ifa.dmem_resp = 1'b0;
        ifa.id_rs1 = 5'd0; ifa.id_rs2 = 5'd0; ifa.id_use_rs1 = 1'b0; ifa.id_use_rs2 = 1'b0;
        ifa.ex_valid = 1'b0; ifa.ex_opcode = op_imm; ifa.ex_br_en = 1'b0; ifa.ex_is_load = 1'b0;
        ifa.ex_rd = 5'd0; ifa.mem_rd = 5'd0; ifa.wb_rd = 5'd0;
        ifa.ex_regwrite = 1'b0; ifa.mem_regwrite = 1'b0; ifa.wb_regwrite = 1'b0;
        ifa.ex_muldiv = 1'b0;
    endtask

    task automatic rand_inputs();
        rst = ($urandom_range(0, 199) == 0);
        ifa.imem_read    = 1'($urandom_range(0, 1));
        ifa.imem_resp    = ($urandom_range(0, 7) != 0);
        ifa.dmem_read    = ($urandom_range(0, 3) == 0);
        ifa.dmem_write   = ($urandom_range(0, 5) == 0);
        ifa.dmem_resp    = ($urandom_range(0, 5) != 0);
        ifa.id_rs1       = 5'($urandom_range(0, 3));
        ifa.id_rs2       = 5'($urandom_range(0, 3));
        ifa.id_use_rs1   = 1'($urandom_range(0, 1));
        ifa.id_use_rs2   = 1'($urandom_range(0, 1));
        ifa.ex_valid     = ($urandom_range(0, 3) != 0);
        ifa.ex_opcode    = op_tab[$urandom_range(0, 6)];
        ifa.ex_br_en     = 1'($urandom_range(0, 1));
        ifa.ex_is_load   = 1'($urandom_range(0, 1));
        ifa.ex_rd        = 5'($urandom_range(0, 3));
        ifa.mem_rd       = 5'($urandom_range(0, 3));
        ifa.wb_rd        = 5'($urandom_range(0, 3));
        ifa.ex_regwrite  = 1'($urandom_range(0, 1));
        ifa.mem_regwrite = 1'($urandom_range(0, 1));
        ifa.wb_regwrite  = 1'($urandom_range(0, 1));
        ifa.ex_muldiv    = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        rst = 1'b1;
        clear();
        tick();
        tick();
        @(negedge clk);
        check("rst.pc_en",   64'(ifa.pc_en), 64'(0));
        check("rst.flushes", 64'({ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush}), 64'(3'b111));
        check("rst.stall",   64'(ifa.stall_cycles), 64'(0));

        // load-use with forwarding
        tick(); rst = 1'b0;
        ifa.ex_valid = 1'b1; ifa.ex_opcode = op_load; ifa.ex_is_load = 1'b1;
        ifa.ex_regwrite = 1'b1; ifa.ex_rd = 5'd5; ifa.id_rs1 = 5'd5; ifa.id_use_rs1 = 1'b1;
        @(negedge clk);
        check("lu.pc_en",      64'(ifa.pc_en), 64'(0));
        check("lu.ifid_en",    64'(ifa.ifid_en), 64'(0));
        check("lu.idex_flush", 64'(ifa.idex_flush), 64'(1));
        tick(); clear();
        @(negedge clk);
        check("lu.resume",     64'({ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.memwb_en}), 64'(5'b11111));
        check("lu.stall_cnt",  64'(ifa.stall_cycles), 64'(1));

        // taken branch, then the same branch as a bubble
        tick(); ifa.ex_valid = 1'b1; ifa.ex_opcode = op_br; ifa.ex_br_en = 1'b1;
        @(negedge clk);
        check("beq.sel",     64'(ifa.pcmux_sel), 64'(alu_out));
        check("beq.flushes", 64'({ifa.ifid_flush, ifa.idex_flush}), 64'(2'b11));
        tick(); ifa.ex_valid = 1'b0;
        @(negedge clk);
        check("beq.flush_cnt",  64'(ifa.flush_events), 64'(1));
        check("bubble.sel",     64'(ifa.pcmux_sel), 64'(pc_plus4));
        check("bubble.flushes", 64'({ifa.ifid_flush, ifa.idex_flush}), 64'(0));

        // jalr beats a simultaneous load-use
        tick(); clear();
        ifa.ex_valid = 1'b1; ifa.ex_opcode = op_jalr; ifa.ex_is_load = 1'b1;
        ifa.ex_regwrite = 1'b1; ifa.ex_rd = 5'd5; ifa.id_rs1 = 5'd5; ifa.id_use_rs1 = 1'b1;
        @(negedge clk);
        check("jalr.sel",   64'(ifa.pcmux_sel), 64'(alu_mod2));
        check("jalr.pc_en", 64'(ifa.pc_en), 64'(1));
        check("jalr.flush", 64'({ifa.ifid_flush, ifa.idex_flush}), 64'(2'b11));

        // WB dependency without forwarding or bypass, then against x0
        tick(); clear();
        ifa.wb_regwrite = 1'b1; ifa.wb_rd = 5'd7; ifa.id_rs2 = 5'd7; ifa.id_use_rs2 = 1'b1;
        @(negedge clk);
        check("wb7.b_pc_en", 64'(ifb.pc_en), 64'(0));
        check("wb7.a_pc_en", 64'(ifa.pc_en), 64'(1));
        tick(); ifa.wb_rd = 5'd0; ifa.id_rs2 = 5'd0;
        @(negedge clk);
        check("wb0.b_pc_en", 64'(ifb.pc_en), 64'(1));

        // mul/div with a 5-cycle dmem stall starting in BUSY
        tick(); clear(); ifa.ex_valid = 1'b1; ifa.ex_muldiv = 1'b1; ifa.ex_opcode = op_reg;
        @(negedge clk);
        check("md0.pc_en", 64'(ifa.pc_en), 64'(0));
        check("md0.exmem_flush", 64'(ifa.exmem_flush), 64'(1));
        check("md0.busy", 64'(ifa.muldiv_busy), 64'(0));
        tick();
        @(negedge clk);
        check("md1.busy", 64'(ifa.muldiv_busy), 64'(1));
        tick(); ifa.dmem_read = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("md4.busy", 64'(ifa.muldiv_busy), 64'(1));
        check("md4.all_en", 64'({ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.memwb_en}), 64'(0));
        tick();
        tick();
        tick(); ifa.dmem_resp = 1'b1;
        @(negedge clk);
        check("md7.pc_en", 64'(ifa.pc_en), 64'(1));
        check("md7.busy",  64'(ifa.muldiv_busy), 64'(1));
        tick(); clear();
        @(negedge clk);
        check("md8.busy", 64'(ifa.muldiv_busy), 64'(0));

        // reset in the middle of BUSY
        tick(); ifa.ex_valid = 1'b1; ifa.ex_muldiv = 1'b1;
        tick();
        @(negedge clk);
        check("mr.busy_pre", 64'(ifa.muldiv_busy), 64'(1));
        tick(); rst = 1'b1;
        @(negedge clk);
        check("mr.pc_en", 64'(ifa.pc_en), 64'(0));
        check("mr.busy",  64'(ifa.muldiv_busy), 64'(0));
        tick(); rst = 1'b0; clear();
        @(negedge clk);
        check("mr.busy_post", 64'(ifa.muldiv_busy), 64'(0));
        check("mr.stall_cnt", 64'(ifa.stall_cycles), 64'(0));
        check("mr.flush_cnt", 64'(ifa.flush_events), 64'(0));

        // 20 stalled cycles: 4-bit counter saturates at 15
        tick(); ifa.imem_read = 1'b1;
        repeat (19) tick();
        tick(); clear();
        @(negedge clk);
        check("sat.b_stall", 64'(ifb.stall_cycles), 64'(15));
        check("sat.a_stall", 64'(ifa.stall_cycles), 64'(20));

        for (int n = 0; n < 3000; n++) begin
            tick();
            rand_inputs();
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/redirect controller for the 5-stage rv32i pipeline (IF, ID, EX, MEM, WB).
- Drives the PC enable and pcmux select, plus per-stage enable and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves memory-response stalls, load-use and RAW hazards (with or without forwarding), and EX-stage control-flow redirects.
- Sequences a multi-cycle mul/div unit and keeps saturating performance counters for stall cycles and flush events.

Parameters:
FWD_EN, 1, 1 = forwarding present (stall only on load-use); 0 = stall on any RAW hazard against EX/MEM/WB.
RF_BYPASS, 1, 1 = regfile writes through, so no hazard is checked against WB.
MULDIV_LAT, 4, mul/div execution cycles, range 2..32.
CNT_W, 32, performance counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_read  in  1  instruction fetch request outstanding
imem_resp  in  1  instruction memory response
dmem_read  in  1  MEM-stage load request
dmem_write  in  1  MEM-stage store request
dmem_resp  in  1  data memory response
id_rs1, id_rs2  in  5 each  ID-stage source registers
id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_opcode  in  rv32i_opcode  EX opcode
ex_br_en  in  1  EX branch comparison result
ex_is_load  in  1  EX instruction is a load
ex_rd, mem_rd, wb_rd  in  5 each  destination registers
ex_regwrite, mem_regwrite, wb_regwrite  in  1 each  register write enables
ex_muldiv  in  1  EX instruction is mul/div
pc_en  out  1  PC register load
pcmux_sel  out  pcmux_sel_t  next-PC select
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register loads
ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble instead
muldiv_busy  out  1  mul/div sequencer not idle
stall_cycles  out  CNT_W  cycles with pc_en=0
flush_events  out  CNT_W  redirects taken

Behaviour:
- Reset (rst=1, synchronous): muldiv FSM -> IDLE; counters -> 0; outputs forced to pc_en=0, all *_en=0, all *_flush=1, pcmux_sel=pc_plus4, muldiv_busy=0.
- mem_stall = (imem_read & ~imem_resp) | ((dmem_read|dmem_write) & ~dmem_resp).
- redirect = ex_valid & ((ex_opcode==op_br & ex_br_en) | op_jal | op_jalr).
- pcmux_sel: alu_out for a taken branch or jal; alu_mod2 for jalr; pc_plus4 otherwise. It is fully defined for every opcode; no latch, no unique-case violation.
- Hazard match condition: the producer has regwrite=1, rd != 0, and rd equals a used source register.
  - FWD_EN=1: hazard = match against EX & ex_is_load.
  - FWD_EN=0: hazard = match against EX | MEM | (WB if RF_BYPASS=0).
- Mul/div FSM: IDLE -> BUSY when ex_valid & ex_muldiv & not mem_stall. The counter loads MULDIV_LAT-1 and decrements every cycle, including mem_stall cycles. At count 0 -> DONE. DONE -> IDLE on the first cycle with no mem_stall, which is the cycle EX advances. muldiv_busy=1 in BUSY and DONE.
- Combinational control priority, highest first:
  1. mem_stall: every en=0, no flush, pcmux_sel=pc_plus4. Global freeze.
  2. muldiv_hold (IDLE with a muldiv entering, or BUSY): pc_en=ifid_en=idex_en=0; exmem_en=1 with exmem_flush=1; memwb_en=1.
  3. redirect: pc_en=1 with the selected pcmux_sel; ifid_flush=idex_flush=1; all en=1. This beats the load-use hazard because the ID instruction is squashed anyway.
  4. hazard: pc_en=ifid_en=0; idex_en=1 with idex_flush=1; downstream en=1.
  5. otherwise: all en=1, no flush, pcmux_sel=pc_plus4.
- Zero latency: all controls are combinational from the current inputs and FSM state.
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_en=0.
  - flush_events increments once per cycle where case 3 is selected.
  - Both saturate at all-ones with no wrap.
- Mid-operation reset: aborts BUSY and returns to IDLE next cycle; the pipeline registers clear themselves.

Decomposition:
- Package hazard_types holds:
  - muldiv_state_t enum {IDLE, BUSY, DONE}
  - hazard_ctrl_t struct grouping the en/flush outputs
  - HZ_CNT_W default constant
- pcmux_sel_t and rv32i_opcode come from the existing pcmux and rv32i_types packages.
- One sub-module, muldiv_sequencer, holds the FSM, counter and muldiv_busy. The top level holds the hazard compare, priority logic and counters.

Test Plan:
- FWD_EN=1, EX lw x5 (regwrite=1), ID add reads x5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1; stall_cycles=1.
- EX beq ex_br_en=1, ex_valid=1 -> pcmux_sel=alu_out, ifid_flush=idex_flush=1, flush_events 0->1. Same with ex_valid=0 -> pc_plus4, no flush.
- EX jalr together with a load-use match in ID -> pcmux_sel=alu_mod2, flushes asserted, pc_en=1 (redirect beats hazard).
- MULDIV_LAT=4, ex_muldiv=1 -> BUSY for 3 cycles then DONE. Hold a dmem stall for 5 cycles starting in BUSY -> all en=0 throughout; DONE persists until dmem_resp; the FSM then returns to IDLE and EX advances.
- FWD_EN=0, RF_BYPASS=0, WB writes x7, ID reads x7 -> stall. Same with rd=x0 -> no stall.
- CNT_W=4 with 20 stalled cycles -> stall_cycles=15 (saturated). rst=1 mid-BUSY -> next cycle IDLE, counters 0, pc_en=0 while rst is held.
